// File: rtl/control_unit_risc_if.sv
// Control bundle between the RISC sequencer and the datapath.
// master: the sequencer (reads IR and Z, drives every control strobe).
// slave : the datapath (ALU, register file, PC/IR/address registers, memory).
// Ports:
//   instruction, zero_flag                 datapath -> sequencer
//   alu_select, reg_rd_a/b, reg_wr_en,
//   reg_wr_addr, wr_sel, load_z, load_ir,
//   inc_pc, load_pc, load_addr, addr_sel,
//   mem_rd, mem_wr, halted                 sequencer -> datapath
interface control_unit_risc_if;
    localparam int unsigned DATAWIDTH   = 8;
    localparam int unsigned OPCODE_SIZE = 4;
    localparam int unsigned REG_ADDR_W  = 2;

    logic [DATAWIDTH-1:0]   instruction;
    logic                   zero_flag;
    logic [OPCODE_SIZE-1:0] alu_select;
    logic [REG_ADDR_W-1:0]  reg_rd_a;
    logic [REG_ADDR_W-1:0]  reg_rd_b;
    logic                   reg_wr_en;
    logic [REG_ADDR_W-1:0]  reg_wr_addr;
    logic                   wr_sel;
    logic                   load_z;
    logic                   load_ir;
    logic                   inc_pc;
    logic                   load_pc;
    logic                   load_addr;
    logic                   addr_sel;
    logic                   mem_rd;
    logic                   mem_wr;
    logic                   halted;

    modport master (
        input  instruction, zero_flag,
        output alu_select, reg_rd_a, reg_rd_b, reg_wr_en, reg_wr_addr, wr_sel,
               load_z, load_ir, inc_pc, load_pc, load_addr, addr_sel,
               mem_rd, mem_wr, halted
    );

    modport slave (
        output instruction, zero_flag,
        input  alu_select, reg_rd_a, reg_rd_b, reg_wr_en, reg_wr_addr, wr_sel,
               load_z, load_ir, inc_pc, load_pc, load_addr, addr_sel,
               mem_rd, mem_wr, halted
    );
endinterface

// File: rtl/control_unit_risc.sv
// Multi-cycle sequencer for the 8-bit RISC core: fetches, decodes the 4-bit
// opcode and steps each instruction through a fixed state sequence, driving
// all datapath control strobes.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset (state -> IDLE, all controls low)
//   bus  control_unit_risc_if.master: IR/Z in, datapath strobes out
// Controls are Moore outputs held in a register that is loaded from the
// decode of the next state, so each strobe is valid for the whole cycle of
// the state it belongs to and clears asynchronously with rst.
module control_unit_risc (
    input  logic                clk,
    input  logic                rst,
    control_unit_risc_if.master bus
);
    localparam int unsigned DATAWIDTH   = 8;
    localparam int unsigned OPCODE_SIZE = 4;
    localparam int unsigned REG_ADDR_W  = 2;

    localparam logic [OPCODE_SIZE-1:0] OP_NOP = 4'd0;
    localparam logic [OPCODE_SIZE-1:0] OP_NOT = 4'd4;
    localparam logic [OPCODE_SIZE-1:0] OP_RD  = 4'd5;
    localparam logic [OPCODE_SIZE-1:0] OP_WR  = 4'd6;
    localparam logic [OPCODE_SIZE-1:0] OP_BR  = 4'd7;
    localparam logic [OPCODE_SIZE-1:0] OP_BRZ = 4'd8;

    typedef enum logic [3:0] {
        S_IDLE, S_FET1, S_FET2, S_DEC, S_EX1, S_FA1, S_FA2,
        S_RD1, S_RD2, S_WR1, S_BR1, S_HALT
    } state_t;

    typedef struct packed {
        logic [OPCODE_SIZE-1:0] alu_select;
        logic [REG_ADDR_W-1:0]  reg_rd_a;
        logic [REG_ADDR_W-1:0]  reg_rd_b;
        logic                   reg_wr_en;
        logic [REG_ADDR_W-1:0]  reg_wr_addr;
        logic                   wr_sel;
        logic                   load_z;
        logic                   load_ir;
        logic                   inc_pc;
        logic                   load_pc;
        logic                   load_addr;
        logic                   addr_sel;
        logic                   mem_rd;
        logic                   mem_wr;
        logic                   halted;
    } ctrl_t;

    state_t state_q, state_d;
    ctrl_t  ctrl_q, ctrl_d;

    logic [OPCODE_SIZE-1:0] opcode;
    logic [REG_ADDR_W-1:0]  src;
    logic [REG_ADDR_W-1:0]  dest;

    // IR fields: [7:4] opcode, [3:2] src, [1:0] dest
    assign opcode = bus.instruction[DATAWIDTH-1 -: OPCODE_SIZE];
    assign src    = bus.instruction[2*REG_ADDR_W-1 -: REG_ADDR_W];
    assign dest   = bus.instruction[REG_ADDR_W-1:0];

    // State and control register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            ctrl_q  <= '0;
        end else begin
            state_q <= state_d;
            ctrl_q  <= ctrl_d;
        end
    end

    // Next-state logic, then control decode of the state being entered.
    // The IR is already stable in DEC/FA2/RD1, i.e. whenever a state that
    // uses IR fields is being entered.
    always_comb begin
        state_d = state_q;
        ctrl_d  = '0;

        case (state_q)
            S_IDLE: state_d = S_FET1;
            S_FET1: state_d = S_FET2;
            S_FET2: state_d = S_DEC;
            S_DEC: begin
                if (opcode == OP_NOP)       state_d = S_FET1;
                else if (opcode <= OP_NOT)  state_d = S_EX1;
                else if (opcode <= OP_BRZ)  state_d = S_FA1;
                else                        state_d = S_HALT;
            end
            S_EX1:  state_d = S_FET1;
            S_FA1:  state_d = S_FA2;
            S_FA2: begin
                case (opcode)
                    OP_RD:   state_d = S_RD1;
                    OP_WR:   state_d = S_WR1;
                    OP_BR:   state_d = S_BR1;
                    OP_BRZ:  state_d = bus.zero_flag ? S_BR1 : S_FET1;
                    default: state_d = S_HALT;
                endcase
            end
            S_RD1:  state_d = S_RD2;
            S_RD2:  state_d = S_FET1;
            S_WR1:  state_d = S_FET1;
            S_BR1:  state_d = S_FET1;
            S_HALT: state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase

        case (state_d)
            S_FET1, S_FA1: begin
                ctrl_d.addr_sel = 1'b0;
                ctrl_d.mem_rd   = 1'b1;
                ctrl_d.inc_pc   = 1'b1;
            end
            S_FET2: ctrl_d.load_ir = 1'b1;
            S_EX1: begin
                ctrl_d.alu_select  = opcode;
                ctrl_d.reg_rd_a    = src;
                // NOT reads src on both ports so dest gets ~R[src]
                ctrl_d.reg_rd_b    = (opcode == OP_NOT) ? src : dest;
                ctrl_d.reg_wr_addr = dest;
                ctrl_d.reg_wr_en   = 1'b1;
                ctrl_d.wr_sel      = 1'b0;
                ctrl_d.load_z      = 1'b1;
            end
            S_FA2: ctrl_d.load_addr = 1'b1;
            S_RD1: begin
                ctrl_d.addr_sel = 1'b1;
                ctrl_d.mem_rd   = 1'b1;
            end
            S_RD2: begin
                ctrl_d.reg_wr_en   = 1'b1;
                ctrl_d.reg_wr_addr = dest;
                ctrl_d.wr_sel      = 1'b1;
            end
            S_WR1: begin
                ctrl_d.addr_sel = 1'b1;
                ctrl_d.mem_wr   = 1'b1;
                ctrl_d.reg_rd_a = src;
            end
            S_BR1:  ctrl_d.load_pc = 1'b1;
            S_HALT: ctrl_d.halted  = 1'b1;
            default: ctrl_d = '0;
        endcase
    end

    assign bus.alu_select  = ctrl_q.alu_select;
    assign bus.reg_rd_a    = ctrl_q.reg_rd_a;
    assign bus.reg_rd_b    = ctrl_q.reg_rd_b;
    assign bus.reg_wr_en   = ctrl_q.reg_wr_en;
    assign bus.reg_wr_addr = ctrl_q.reg_wr_addr;
    assign bus.wr_sel      = ctrl_q.wr_sel;
    assign bus.load_z      = ctrl_q.load_z;
    assign bus.load_ir     = ctrl_q.load_ir;
    assign bus.inc_pc      = ctrl_q.inc_pc;
    assign bus.load_pc     = ctrl_q.load_pc;
    assign bus.load_addr   = ctrl_q.load_addr;
    assign bus.addr_sel    = ctrl_q.addr_sel;
    assign bus.mem_rd      = ctrl_q.mem_rd;
    assign bus.mem_wr      = ctrl_q.mem_wr;
    assign bus.halted      = ctrl_q.halted;
endmodule

// File: tb/tb_control_unit_risc.sv
// Bench for control_unit_risc: directed instruction table, reset/halt
// sequences, and a random program checked cycle by cycle against an
// instruction-level model expanded into per-cycle control expectations.
module tb_control_unit_risc;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    control_unit_risc_if bus ();

    control_unit_risc dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [3:0] alu;
        logic [1:0] rd_a;
        logic [1:0] rd_b;
        logic       wr_en;
        logic [1:0] wr_addr;
        logic       wr_sel;
        logic       load_z;
        logic       load_ir;
        logic       inc_pc;
        logic       load_pc;
        logic       load_addr;
        logic       addr_sel;
        logic       mem_rd;
        logic       mem_wr;
        logic       halted;
    } outs_t;

    typedef struct {
        logic [7:0] ir;
        logic       zf;
        int         cpi;
        logic [11:0] wsig;   // {alu, rd_a, rd_b, wr_addr, wr_sel, load_z} at first write
        int         n_rd;
        int         n_pc;
        int         n_addr;
    } vec_t;

    typedef struct {
        logic [7:0] ir;
        logic       zf;
        outs_t      exp;
    } row_t;

    int n_checks = 0;
    int n_fail   = 0;

    vec_t       vecs [10];
    row_t       rows [$];
    logic [7:0] mem  [256];

    function automatic outs_t sample();
        outs_t o;
        o.alu       = bus.alu_select;
        o.rd_a      = bus.reg_rd_a;
        o.rd_b      = bus.reg_rd_b;
        o.wr_en     = bus.reg_wr_en;
        o.wr_addr   = bus.reg_wr_addr;
        o.wr_sel    = bus.wr_sel;
        o.load_z    = bus.load_z;
        o.load_ir   = bus.load_ir;
        o.inc_pc    = bus.inc_pc;
        o.load_pc   = bus.load_pc;
        o.load_addr = bus.load_addr;
        o.addr_sel  = bus.addr_sel;
        o.mem_rd    = bus.mem_rd;
        o.mem_wr    = bus.mem_wr;
        o.halted    = bus.halted;
        return o;
    endfunction

    task automatic check(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // Leaves the bench #1 into the IDLE cycle right after rst falls
    task automatic do_reset();
        rst = 1'b1;
        bus.instruction = 8'h00;
        bus.zero_flag = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    function automatic outs_t fetch_row();
        outs_t e = '0;
        e.mem_rd = 1'b1;
        e.inc_pc = 1'b1;
        return e;
    endfunction

    // Run one instruction from reset; measure FET2-to-FET2 cycles and strobes
    task automatic run_vec(input vec_t v, input int idx);
        outs_t o;
        int phase = 0, cpi = 0, n_rd = 0, n_pc = 0, n_addr = 0;
        logic [11:0] wsig = '0;
        bit got_w = 0, pend = 0, done = 0;
        do_reset();
        bus.zero_flag = v.zf;
        for (int c = 0; c < 40 && !done; c++) begin
            @(posedge clk);
            #1;
            o = sample();
            if (pend) begin
                bus.instruction = v.ir;
                pend = 0;
            end
            if (phase == 0) begin
                if (o.load_ir) begin
                    phase = 1;
                    pend = 1;
                end
            end else begin
                cpi++;
                n_rd   += int'(o.mem_rd);
                n_pc   += int'(o.load_pc);
                n_addr += int'(o.load_addr);
                if ((o.wr_en || o.mem_wr) && !got_w) begin
                    got_w = 1;
                    wsig = {o.alu, o.rd_a, o.rd_b, o.wr_addr, o.wr_sel, o.load_z};
                end
                if (o.load_ir) done = 1;
            end
        end
        if (!done) begin
            check($sformatf("vec%0d_ir%0h_timeout", idx, v.ir), 0, 1);
        end else begin
            check($sformatf("vec%0d_ir%0h_cpi", idx, v.ir), cpi, v.cpi);
            check($sformatf("vec%0d_ir%0h_write_fields", idx, v.ir), int'(wsig), int'(v.wsig));
            check($sformatf("vec%0d_ir%0h_mem_rd_count", idx, v.ir), n_rd, v.n_rd);
            check($sformatf("vec%0d_ir%0h_load_pc_count", idx, v.ir), n_pc, v.n_pc);
            check($sformatf("vec%0d_ir%0h_load_addr_count", idx, v.ir), n_addr, v.n_addr);
        end
    endtask

    // Wait (bounded) for the first FET2 after reset, then present ir in DEC
    task automatic load_first(input logic [7:0] ir, output bit ok);
        outs_t o;
        ok = 0;
        for (int c = 0; c < 10 && !ok; c++) begin
            @(posedge clk);
            #1;
            o = sample();
            if (o.load_ir) ok = 1;
        end
        if (ok) begin
            @(posedge clk);
            #1;
            bus.instruction = ir;
        end
    endtask

    task automatic reset_test();
        outs_t o;
        bit ok;
        int lat = -1;
        do_reset();
        load_first(8'h1B, ok);
        for (int c = 1; c < 10 && ok && lat < 0; c++) begin
            @(posedge clk);
            #1;
            o = sample();
            if (o.wr_en) lat = c;
        end
        check("reset_ex1_reached", lat, 1);
        #2;
        rst = 1'b1;
        #1;
        o = sample();
        check("reset_wr_en_drops", int'(o.wr_en), 0);
        check("reset_all_zero", int'(o), 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        bus.instruction = 8'h00;
        check("reset_idle_outputs", int'(sample()), 0);
        @(posedge clk);
        #1;
        check("reset_first_fet1", int'(sample()), int'(fetch_row()));
    endtask

    task automatic halt_test();
        outs_t o;
        bit ok;
        int lat = -1, n_h = 0, n_rd = 0;
        do_reset();
        load_first(8'hF0, ok);
        for (int c = 1; c < 10 && ok && lat < 0; c++) begin
            @(posedge clk);
            #1;
            o = sample();
            if (o.halted) lat = c;
        end
        check("halt_entry", lat, 1);
        for (int c = 0; c < 25; c++) begin
            @(posedge clk);
            #1;
            o = sample();
            n_h  += int'(o.halted);
            n_rd += int'(o.mem_rd);
        end
        check("halt_held", n_h, 25);
        check("halt_no_mem_rd", n_rd, 0);
        check("halt_only_output", int'(o), 1);
        rst = 1'b1;
        #1;
        check("halt_cleared_by_rst", int'(bus.halted), 0);
    endtask

    // Instruction-level model: execute the program, emitting each
    // instruction's per-cycle control template
    task automatic build_rows(input int n_instr);
        logic [7:0] pc = 8'h00, prev = 8'h00, instr, addr;
        logic [3:0] op;
        logic [1:0] s, d;
        logic z;
        outs_t e;
        rows.delete();
        rows.push_back('{8'h00, 1'b0, outs_t'('0)});
        for (int n = 0; n < n_instr; n++) begin
            instr = mem[pc];
            pc = pc + 8'd1;
            z = 1'($urandom);
            op = instr[7:4];
            s  = instr[3:2];
            d  = instr[1:0];
            rows.push_back('{prev, z, fetch_row()});
            e = '0; e.load_ir = 1'b1;
            rows.push_back('{prev, z, e});
            rows.push_back('{instr, z, outs_t'('0)});
            if (op >= 4'd1 && op <= 4'd4) begin
                e = '0;
                e.alu = op; e.rd_a = s; e.rd_b = (op == 4'd4) ? s : d;
                e.wr_addr = d; e.wr_en = 1'b1; e.load_z = 1'b1;
                rows.push_back('{instr, z, e});
            end else if (op >= 4'd5) begin
                addr = mem[pc];
                pc = pc + 8'd1;
                rows.push_back('{instr, z, fetch_row()});
                e = '0; e.load_addr = 1'b1;
                rows.push_back('{instr, z, e});
                if (op == 4'd5) begin
                    e = '0; e.addr_sel = 1'b1; e.mem_rd = 1'b1;
                    rows.push_back('{instr, z, e});
                    e = '0; e.wr_en = 1'b1; e.wr_addr = d; e.wr_sel = 1'b1;
                    rows.push_back('{instr, z, e});
                end else if (op == 4'd6) begin
                    e = '0; e.addr_sel = 1'b1; e.mem_wr = 1'b1; e.rd_a = s;
                    rows.push_back('{instr, z, e});
                end else if (op == 4'd7 || z) begin
                    e = '0; e.load_pc = 1'b1;
                    rows.push_back('{instr, z, e});
                    pc = addr;
                end
            end
            prev = instr;
        end
    endtask

    task automatic random_test();
        for (int i = 0; i < 256; i++)
            mem[i] = {4'($urandom_range(0, 8)), 4'($urandom)};
        build_rows(150);
        do_reset();
        for (int k = 0; k < rows.size(); k++) begin
            if (k > 0) begin
                @(posedge clk);
                #1;
            end
            check($sformatf("rand_cycle%0d", k), int'(sample()), int'(rows[k].exp));
            bus.instruction = rows[k].ir;
            bus.zero_flag = rows[k].zf;
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.instruction = 8'h00;
        bus.zero_flag = 1'b0;

        vecs[0] = '{8'h00, 1'b0, 3, 12'h000, 1, 0, 0};
        vecs[1] = '{8'h1B, 1'b0, 4, 12'({4'd1, 2'd2, 2'd3, 2'd3, 1'b0, 1'b1}), 1, 0, 0};
        vecs[2] = '{8'h2B, 1'b1, 4, 12'({4'd2, 2'd2, 2'd3, 2'd3, 1'b0, 1'b1}), 1, 0, 0};
        vecs[3] = '{8'h36, 1'b0, 4, 12'({4'd3, 2'd1, 2'd2, 2'd2, 1'b0, 1'b1}), 1, 0, 0};
        vecs[4] = '{8'h46, 1'b0, 4, 12'({4'd4, 2'd1, 2'd1, 2'd2, 1'b0, 1'b1}), 1, 0, 0};
        vecs[5] = '{8'h51, 1'b0, 7, 12'({4'd0, 2'd0, 2'd0, 2'd1, 1'b1, 1'b0}), 3, 0, 1};
        vecs[6] = '{8'h64, 1'b0, 6, 12'({4'd0, 2'd1, 2'd0, 2'd0, 1'b0, 1'b0}), 2, 0, 1};
        vecs[7] = '{8'h70, 1'b0, 6, 12'h000, 2, 1, 1};
        vecs[8] = '{8'h80, 1'b0, 5, 12'h000, 2, 0, 1};
        vecs[9] = '{8'h80, 1'b1, 6, 12'h000, 2, 1, 1};

        for (int i = 0; i < 10; i++) run_vec(vecs[i], i);
        reset_test();
        halt_test();
        random_test();

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end
endmodule
